memory_io_ctrl: RTL and testbench
=================================

Name: memory_io_ctrl

Overview:
Parametrised memory-mapped I/O controller between the core's memory interface and the synchronous data RAM.
- Decodes an I/O window at the top of the address space.
- Registers NUM_OUT output ports and synchronises NUM_IN input ports.
- Keeps a sticky input-change status register.
- Aligns I/O read data with the RAM's one-cycle read latency, so the core sees one uniform memory timing.

Parameters:
ADDR_BITS, 16, memory address width
DATA_BITS, 8, memory data width and port width
NUM_OUT, 4, number of output ports (1..8)
NUM_IN, 3, number of input ports (1..DATA_BITS)
IO_BASE, 2**ADDR_BITS-8 ('hfff8), first I/O address; window is IO_BASE..IO_BASE+NUM_OUT+NUM_IN inclusive

Ports:
clk  in  1  system clock, all state on rising edge
reset  in  1  synchronous, active-high reset
rd_mem_en  in  1  core read request
rd_mem_addr  in  ADDR_BITS  core read address
rd_mem_data  out  DATA_BITS  read data, valid the cycle after rd_mem_en
wr_mem_en  in  1  core write request
wr_mem_addr  in  ADDR_BITS  core write address
wr_mem_data  in  DATA_BITS  core write data
rd_ram_en  out  1  RAM read enable
rd_ram_addr  out  ADDR_BITS  RAM read address
rd_ram_data  in  DATA_BITS  RAM read data (1-cycle latency)
wr_ram_en  out  1  RAM write enable
wr_ram_addr  out  ADDR_BITS  RAM write address
wr_ram_data  out  DATA_BITS  RAM write data
out_ports  out  NUM_OUT*DATA_BITS  registered output port values, port i at bits [i*DATA_BITS +: DATA_BITS]
out_write_strobe  out  NUM_OUT  one-cycle pulse per port write
in_ports  in  NUM_IN*DATA_BITS  asynchronous input port values

Behaviour:
- Clocking and reset:
  - Single clock clk; reset is synchronous and active-high.
  - On reset: out_ports=0, out_write_strobe=0, rd_mem_data=0, status=0, sync flops=0, prev-sample=0.
- Address map (offset = addr-IO_BASE):
  - Output port i at offset i.
  - Input port j at offset NUM_OUT+j.
  - STATUS at offset NUM_OUT+NUM_IN.
  - Every address outside the window goes to RAM.
- RAM path (combinational):
  - rd_ram_en = rd_mem_en & ~in_window(rd_mem_addr); wr_ram_en likewise for writes.
  - rd_ram_addr, wr_ram_addr and wr_ram_data pass straight through.
- Output port writes:
  - A write to output port i updates that port's register on the clock edge.
  - out_write_strobe[i] is high for exactly the following cycle, coincident with the new value.
  - A new write on the next cycle re-asserts the strobe (back-to-back pulses are allowed).
- Ignored writes: writes to input-port or STATUS addresses change no state and do not reach RAM.
- Input synchronisation:
  - Each input port goes through a 2-flop synchroniser; the synchronised value is the readable value.
  - Change detect: the synchronised value is compared with its previous-cycle sample; any difference sets STATUS bit j.
- Read path (1-cycle latency for every source):
  - A registered source select plus a registered I/O data capture feed rd_mem_data.
  - RAM read: rd_mem_data = rd_ram_data in the cycle after the request.
  - Output port read: value before any same-cycle write (read-old).
  - Input port read: synchronised value at the request edge.
  - STATUS read: bits [NUM_IN-1:0] are flags, upper bits are 0.
- STATUS clear-on-read:
  - A STATUS read clears the flags it returned.
  - A change detected in the same cycle as the read sets its bit again (set wins over clear).
- rd_mem_data hold: when no read occurred in the previous cycle, rd_mem_data holds its last value.
- Reset mid-operation: a read pending at the reset edge is discarded, and rd_mem_data=0 the next cycle.
- Simultaneous read and write to different I/O addresses are fully independent.

Optional Feature:
MEMORY_IO_READBACK_EN
- Defined: reads of output-port addresses return the latched port value (read-old rule above).
- Undefined: output-port reads return 0, and the output registers have no read-mux input.
- All other behaviour is identical in both builds.

Test Plan:
- Reset, then write 'h5A to 'hfff9 -> next cycle out_ports[15:8]='h5A and out_write_strobe='b0010 for exactly 1 cycle; other ports remain 0.
- Write 'h33 to 'h0100, then read 'h0100 -> wr_ram_en=1, rd_ram_en=1, rd_mem_data='h33 one cycle after the read; no strobes.
- Drive in_ports port1='hC3 -> STATUS bit1 set 3 cycles later; read 'hfffd -> 'hC3; read 'hffff -> 'h02, then reread -> 'h00.
- Input port0 toggles in the same cycle as a STATUS read -> read returns the old flags, and bit0 is still set afterwards.
- With MEMORY_IO_READBACK_EN: write 'h11 to 'hfff8 and read 'hfff8 in the same cycle -> 'h00 (old value); read again -> 'h11. Without the macro -> 'h00 both times.
- Write to 'hfffc (input port addr), then assert reset during a pending read -> no RAM write, in_ports unaffected; rd_mem_data=0 and all outputs 0 after reset.

Source files
------------

// File: rtl/memory_io_ctrl_if.sv
// Bus bundle for memory_io_ctrl: core memory port, data-RAM port and I/O pins.
// slave = the controller, master = the core/RAM/pin side that drives it.
interface memory_io_ctrl_if #(
    parameter int ADDR_BITS = 16,
    parameter int DATA_BITS = 8,
    parameter int NUM_OUT   = 4,
    parameter int NUM_IN    = 3
) ();
    logic                          rd_mem_en;
    logic [ADDR_BITS-1:0]          rd_mem_addr;
    logic [DATA_BITS-1:0]          rd_mem_data;
    logic                          wr_mem_en;
    logic [ADDR_BITS-1:0]          wr_mem_addr;
    logic [DATA_BITS-1:0]          wr_mem_data;
    logic                          rd_ram_en;
    logic [ADDR_BITS-1:0]          rd_ram_addr;
    logic [DATA_BITS-1:0]          rd_ram_data;
    logic                          wr_ram_en;
    logic [ADDR_BITS-1:0]          wr_ram_addr;
    logic [DATA_BITS-1:0]          wr_ram_data;
    logic [NUM_OUT*DATA_BITS-1:0]  out_ports;
    logic [NUM_OUT-1:0]            out_write_strobe;
    logic [NUM_IN*DATA_BITS-1:0]   in_ports;

    modport slave (
        input  rd_mem_en, rd_mem_addr, wr_mem_en, wr_mem_addr, wr_mem_data,
        input  rd_ram_data, in_ports,
        output rd_mem_data, rd_ram_en, rd_ram_addr, wr_ram_en, wr_ram_addr, wr_ram_data,
        output out_ports, out_write_strobe
    );

    modport master (
        output rd_mem_en, rd_mem_addr, wr_mem_en, wr_mem_addr, wr_mem_data,
        output rd_ram_data, in_ports,
        input  rd_mem_data, rd_ram_en, rd_ram_addr, wr_ram_en, wr_ram_addr, wr_ram_data,
        input  out_ports, out_write_strobe
    );
endinterface

// File: rtl/memory_io_ctrl.sv
// Memory-mapped I/O controller: I/O window at the top of memory, everything else to RAM.
// Define MEMORY_IO_READBACK_EN to make output-port addresses readable.
module memory_io_ctrl #(
    parameter int                   ADDR_BITS = 16,
    parameter int                   DATA_BITS = 8,
    parameter int                   NUM_OUT   = 4,
    parameter int                   NUM_IN    = 3,
    parameter logic [ADDR_BITS-1:0] IO_BASE   = {ADDR_BITS{1'b1}} - ADDR_BITS'(7)
) (
    input logic              clk,
    input logic              reset,
    memory_io_ctrl_if.slave  bus
);
    localparam logic [ADDR_BITS-1:0] STATUS_OFF = ADDR_BITS'(NUM_OUT + NUM_IN);
    localparam logic [1:0] SEL_NONE = 2'd0;
    localparam logic [1:0] SEL_RAM  = 2'd1;
    localparam logic [1:0] SEL_IO   = 2'd2;

    logic [DATA_BITS-1:0] r_out      [NUM_OUT];
    logic [NUM_OUT-1:0]   r_strobe;
    logic [DATA_BITS-1:0] r_sync_p1  [NUM_IN];
    logic [DATA_BITS-1:0] r_sync_p2  [NUM_IN];
    logic [DATA_BITS-1:0] r_prev     [NUM_IN];
    logic [NUM_IN-1:0]    r_status;
    logic [1:0]           r_rd_sel_p1;
    logic [DATA_BITS-1:0] r_io_data_p1;
    logic [DATA_BITS-1:0] r_hold;

    logic [ADDR_BITS-1:0] w_rd_off;
    logic [ADDR_BITS-1:0] w_wr_off;
    logic                 w_rd_io;
    logic                 w_wr_io;
    logic                 w_status_rd;
    logic [NUM_IN-1:0]    w_change;
    logic [DATA_BITS-1:0] w_io_rd;
    logic [DATA_BITS-1:0] w_rd_data;

    // Window decode: offset wraps, so the lower bound is checked separately
    assign w_rd_off    = bus.rd_mem_addr - IO_BASE;
    assign w_wr_off    = bus.wr_mem_addr - IO_BASE;
    assign w_rd_io     = (bus.rd_mem_addr >= IO_BASE) && (w_rd_off <= STATUS_OFF);
    assign w_wr_io     = (bus.wr_mem_addr >= IO_BASE) && (w_wr_off <= STATUS_OFF);
    assign w_status_rd = bus.rd_mem_en && w_rd_io && (w_rd_off == STATUS_OFF);

    assign bus.rd_ram_en   = bus.rd_mem_en & ~w_rd_io;
    assign bus.rd_ram_addr = bus.rd_mem_addr;
    assign bus.wr_ram_en   = bus.wr_mem_en & ~w_wr_io;
    assign bus.wr_ram_addr = bus.wr_mem_addr;
    assign bus.wr_ram_data = bus.wr_mem_data;

    for (genvar g = 0; g < NUM_OUT; g++) begin : g_out
        assign bus.out_ports[g*DATA_BITS +: DATA_BITS] = r_out[g];
    end
    assign bus.out_write_strobe = r_strobe;

    always_comb begin
        w_change = '0;
        for (int j = 0; j < NUM_IN; j++) begin
            w_change[j] = (r_sync_p2[j] != r_prev[j]);
        end
    end

    always_comb begin
        w_io_rd = '0;
        if (w_rd_off == STATUS_OFF) begin
            w_io_rd = DATA_BITS'(r_status);
        end
        for (int j = 0; j < NUM_IN; j++) begin
            if (w_rd_off == ADDR_BITS'(NUM_OUT + j)) begin
                w_io_rd = r_sync_p2[j];
            end
        end
`ifdef MEMORY_IO_READBACK_EN
        for (int i = 0; i < NUM_OUT; i++) begin
            if (w_rd_off == ADDR_BITS'(i)) begin
                w_io_rd = r_out[i];
            end
        end
`endif
    end

    // p1: read source chosen at the request edge, data aligned with RAM latency
    always_comb begin
        case (r_rd_sel_p1)
            SEL_RAM: w_rd_data = bus.rd_ram_data;
            SEL_IO:  w_rd_data = r_io_data_p1;
            default: w_rd_data = r_hold;
        endcase
    end
    assign bus.rd_mem_data = w_rd_data;

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NUM_OUT; i++) begin
                r_out[i] <= '0;
            end
            for (int j = 0; j < NUM_IN; j++) begin
                r_sync_p1[j] <= '0;
                r_sync_p2[j] <= '0;
                r_prev[j]    <= '0;
            end
            r_strobe     <= '0;
            r_status     <= '0;
            r_rd_sel_p1  <= SEL_NONE;
            r_io_data_p1 <= '0;
            r_hold       <= '0;
        end else begin
            for (int i = 0; i < NUM_OUT; i++) begin
                r_strobe[i] <= bus.wr_mem_en && w_wr_io && (w_wr_off == ADDR_BITS'(i));
                if (bus.wr_mem_en && w_wr_io && (w_wr_off == ADDR_BITS'(i))) begin
                    r_out[i] <= bus.wr_mem_data;
                end
            end
            for (int j = 0; j < NUM_IN; j++) begin
                r_sync_p1[j] <= bus.in_ports[j*DATA_BITS +: DATA_BITS];
                r_sync_p2[j] <= r_sync_p1[j];
                r_prev[j]    <= r_sync_p2[j];
            end
            // A change seen in the read cycle survives the clear
            r_status <= w_status_rd ? w_change : (r_status | w_change);
            r_hold   <= w_rd_data;
            if (bus.rd_mem_en) begin
                r_rd_sel_p1  <= w_rd_io ? SEL_IO : SEL_RAM;
                r_io_data_p1 <= w_io_rd;
            end else begin
                r_rd_sel_p1  <= SEL_NONE;
            end
        end
    end
endmodule

// File: tb/tb_memory_io_ctrl.sv
// Directed plus random bench for memory_io_ctrl against a cycle-level reference model.
module tb_memory_io_ctrl;
    localparam int AB = 16;
    localparam int DB = 8;
    localparam int NO = 4;
    localparam int NI = 3;
    localparam logic [15:0] BASE = 16'hFFF8;
`ifdef MEMORY_IO_READBACK_EN
    localparam bit RB = 1'b1;
`else
    localparam bit RB = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset;
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    memory_io_ctrl_if #(.ADDR_BITS(AB), .DATA_BITS(DB), .NUM_OUT(NO), .NUM_IN(NI)) bus ();

    memory_io_ctrl #(.ADDR_BITS(AB), .DATA_BITS(DB), .NUM_OUT(NO), .NUM_IN(NI)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    // Synchronous RAM, one-cycle read latency, read returns the pre-write contents
    logic [7:0] ram [16] = '{default: 8'h00};
    always @(posedge clk) begin
        if (bus.rd_ram_en) bus.rd_ram_data <= ram[bus.rd_ram_addr[3:0]];
        if (bus.wr_ram_en) ram[bus.wr_ram_addr[3:0]] <= bus.wr_ram_data;
    end

    // Reference model state
    logic [7:0]  ref_ram [16] = '{default: 8'h00};
    logic [7:0]  exp_out [NO];
    logic [3:0]  exp_strobe;
    logic [2:0]  exp_status;
    logic [7:0]  exp_rd;
    logic [23:0] h1, h2, h3;   // in_ports seen at the last three edges, newest first

    function automatic bit inwin(input logic [15:0] a);
        return a >= BASE;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_edge();
        logic [2:0] chg;
        int off;
        if (bus.wr_mem_en && !inwin(bus.wr_mem_addr)) ref_ram[bus.wr_mem_addr[3:0]] = bus.wr_mem_data;
        if (reset) begin
            for (int i = 0; i < NO; i++) exp_out[i] = 8'h00;
            exp_strobe = 4'h0; exp_status = 3'h0; exp_rd = 8'h00;
            h1 = '0; h2 = '0; h3 = '0;
        end else begin
            for (int j = 0; j < NI; j++) chg[j] = (h2[j*8 +: 8] != h3[j*8 +: 8]);
            if (bus.rd_mem_en) begin
                if (inwin(bus.rd_mem_addr)) begin
                    off = int'(bus.rd_mem_addr - BASE);
                    if (off < NO)           exp_rd = RB ? exp_out[off] : 8'h00;
                    else if (off < NO + NI) exp_rd = h2[(off-NO)*8 +: 8];
                    else                    exp_rd = {5'b0, exp_status};
                end else begin
                    exp_rd = ref_ram[bus.rd_mem_addr[3:0]];
                end
            end
            exp_status = (bus.rd_mem_en && bus.rd_mem_addr == 16'hFFFF) ? chg : (exp_status | chg);
            exp_strobe = 4'h0;
            if (bus.wr_mem_en && inwin(bus.wr_mem_addr)) begin
                off = int'(bus.wr_mem_addr - BASE);
                if (off < NO) begin
                    exp_out[off] = bus.wr_mem_data;
                    exp_strobe[off] = 1'b1;
                end
            end
            h3 = h2; h2 = h1; h1 = bus.in_ports;
        end
    endtask

    task automatic tick();
        #1;
        chk("rd_ram_en",   bus.rd_ram_en,   bus.rd_mem_en & ~inwin(bus.rd_mem_addr));
        chk("wr_ram_en",   bus.wr_ram_en,   bus.wr_mem_en & ~inwin(bus.wr_mem_addr));
        chk("rd_ram_addr", bus.rd_ram_addr, bus.rd_mem_addr);
        chk("wr_ram_addr", bus.wr_ram_addr, bus.wr_mem_addr);
        chk("wr_ram_data", bus.wr_ram_data, bus.wr_mem_data);
        model_edge();
        @(posedge clk);
        #1;
        chk("rd_mem_data", bus.rd_mem_data, exp_rd);
        chk("out_ports",   bus.out_ports,   {exp_out[3], exp_out[2], exp_out[1], exp_out[0]});
        chk("strobe",      bus.out_write_strobe, exp_strobe);
    endtask

    task automatic drive(input logic re, input logic [15:0] ra,
                         input logic we, input logic [15:0] wa, input logic [7:0] wd);
        bus.rd_mem_en = re; bus.rd_mem_addr = ra;
        bus.wr_mem_en = we; bus.wr_mem_addr = wa; bus.wr_mem_data = wd;
    endtask

    task automatic idle();
        drive(1'b0, 16'h0000, 1'b0, 16'h0000, 8'h00);
    endtask

    function automatic logic [15:0] pick_addr();
        if ($urandom_range(0, 1) == 0) return BASE + 16'($urandom_range(0, 7));
        return 16'h0100 + 16'($urandom_range(0, 15));
    endfunction

    initial begin
        reset = 1'b1;
        bus.in_ports = '0;
        idle();
        tick();
        tick();
        chk("reset_rd",     bus.rd_mem_data, 8'h00);
        chk("reset_ports",  bus.out_ports, 32'h0);
        chk("reset_strobe", bus.out_write_strobe, 4'h0);
        reset = 1'b0;

        // Output port 1 write
        drive(1'b0, 16'h0, 1'b1, 16'hFFF9, 8'h5A);
        tick();
        chk("tp1_port1",  bus.out_ports[15:8], 8'h5A);
        chk("tp1_others", bus.out_ports & 32'hFFFF00FF, 32'h0);
        chk("tp1_strobe", bus.out_write_strobe, 4'b0010);
        idle();
        tick();
        chk("tp1_strobe_off", bus.out_write_strobe, 4'b0000);

        // RAM write then read
        drive(1'b0, 16'h0, 1'b1, 16'h0100, 8'h33);
        #1 chk("tp2_wr_ram_en", bus.wr_ram_en, 1'b1);
        tick();
        drive(1'b1, 16'h0100, 1'b0, 16'h0, 8'h00);
        #1 chk("tp2_rd_ram_en", bus.rd_ram_en, 1'b1);
        tick();
        chk("tp2_rd", bus.rd_mem_data, 8'h33);
        chk("tp2_no_strobe", bus.out_write_strobe, 4'h0);

        // Input port 1 change, read, sticky status and clear-on-read
        idle();
        bus.in_ports = 24'h00C300;
        tick(); tick(); tick();
        drive(1'b1, 16'hFFFD, 1'b0, 16'h0, 8'h00);
        tick();
        chk("tp3_in1", bus.rd_mem_data, 8'hC3);
        idle();
        tick();
        chk("tp3_hold", bus.rd_mem_data, 8'hC3);
        drive(1'b1, 16'hFFFF, 1'b0, 16'h0, 8'h00);
        tick();
        chk("tp3_status", bus.rd_mem_data, 8'h02);
        tick();
        chk("tp3_status_clr", bus.rd_mem_data, 8'h00);

        // Port 0 change lands on the same edge as a STATUS read
        idle();
        bus.in_ports = 24'h55C300;
        tick(); tick(); tick();
        bus.in_ports = 24'h55C301;
        tick(); tick();
        drive(1'b1, 16'hFFFF, 1'b0, 16'h0, 8'h00);
        tick();
        chk("tp4_old_flags", bus.rd_mem_data, 8'h04);
        tick();
        chk("tp4_set_wins", bus.rd_mem_data, 8'h01);
        tick();
        chk("tp4_cleared", bus.rd_mem_data, 8'h00);

        // Same-cycle write and read of output port 0
        drive(1'b1, 16'hFFF8, 1'b1, 16'hFFF8, 8'h11);
        tick();
        chk("tp5_read_old", bus.rd_mem_data, 8'h00);
        chk("tp5_strobe", bus.out_write_strobe, 4'b0001);
        drive(1'b1, 16'hFFF8, 1'b0, 16'h0, 8'h00);
        tick();
        chk("tp5_readback", bus.rd_mem_data, RB ? 8'h11 : 8'h00);

        // Ignored write to an input-port address, then reset over a pending read
        drive(1'b0, 16'h0, 1'b1, 16'hFFFC, 8'hAA);
        #1 chk("tp6_no_ram_wr", bus.wr_ram_en, 1'b0);
        tick();
        chk("tp6_ports_kept", bus.out_ports, 32'h00005A11);
        chk("tp6_no_strobe", bus.out_write_strobe, 4'h0);
        drive(1'b1, 16'h0100, 1'b0, 16'h0, 8'h00);
        tick();
        chk("tp6_rd_before", bus.rd_mem_data, 8'h33);
        reset = 1'b1;
        tick();
        chk("tp6_rd_reset", bus.rd_mem_data, 8'h00);
        chk("tp6_ports_reset", bus.out_ports, 32'h0);
        reset = 1'b0;
        idle();
        tick();
        chk("tp6_rd_after", bus.rd_mem_data, 8'h00);

        // Random traffic against the model
        for (int n = 0; n < 400; n++) begin
            reset = ($urandom_range(0, 63) == 0);
            drive(1'($urandom_range(0, 1)), pick_addr(),
                  1'($urandom_range(0, 1)), pick_addr(), 8'($urandom));
            if ($urandom_range(0, 7) == 0) bus.in_ports = 24'($urandom);
            tick();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
